// File: rtl/led_level_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_level_pkg
// Shared types and constants for the LED brightness-level generator:
//   state_e      - level FSM states (MANUAL / RAMP_UP / RAMP_DOWN)
//   LEVEL_W      - brightness level width
//   LEVEL_MAX/MIN- saturation bounds of the level
//   GAMMA_TABLE  - 16-entry perceptual gamma map, entry 0 in the low nibble
//   gamma_lookup - indexes GAMMA_TABLE by a linear level
// ----------------------------------------------------------------------------
package led_level_pkg;

    localparam int unsigned LEVEL_W   = 4;
    localparam int unsigned LEVEL_NUM = 16;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam logic [LEVEL_W-1:0] LEVEL_MIN = '0;

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_e;

    // Entries 15..0 from MSB to LSB: 15,13,11,9,7,6,5,4,3,2,2,1,1,1,0,0
    localparam logic [LEVEL_NUM*LEVEL_W-1:0] GAMMA_TABLE = 64'hFDB9_7654_3221_1100;

    function automatic logic [LEVEL_W-1:0] gamma_lookup(input logic [LEVEL_W-1:0] level);
        return GAMMA_TABLE[int'(level)*LEVEL_W +: LEVEL_W];
    endfunction

endpackage

// File: rtl/led_level_ctrl_if.sv
// ----------------------------------------------------------------------------
// led_level_ctrl_if
// Button/switch inputs and level outputs of led_level_ctrl.
//   btn_up, btn_down - raw push-buttons (asynchronous, bouncing)
//   mode             - raw slide switch, 0 = manual, 1 = breathe
//   duty_cycle       - level presented to the PWM stage
//   at_max, at_min   - linear level at its upper / lower bound
// master: drives the raw inputs (board / bench side)
// slave : the level generator itself
// ----------------------------------------------------------------------------
interface led_level_ctrl_if;
    import led_level_pkg::*;

    logic               btn_up;
    logic               btn_down;
    logic               mode;
    logic [LEVEL_W-1:0] duty_cycle;
    logic               at_max;
    logic               at_min;

    modport master (
        output btn_up,
        output btn_down,
        output mode,
        input  duty_cycle,
        input  at_max,
        input  at_min
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  mode,
        output duty_cycle,
        output at_max,
        output at_min
    );

endinterface

// File: rtl/led_level_ctrl_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, counter debouncer and rising-edge press pulse.
// Parameter:
//   DB_CYCLES - consecutive differing samples needed before the stable level
//               flips (>= 2)
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   btn_raw in  raw asynchronous button
//   press   out one-cycle pulse on each 0->1 flip of the debounced level
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Count while the synchronised input disagrees; flip once the count is full
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                press_d  = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            meta_q   <= btn_raw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_level_ctrl.sv
// ----------------------------------------------------------------------------
// led_level_ctrl
// Brightness-level generator feeding a PWM dimmer. Manual mode steps a
// saturating 4-bit level with two debounced buttons; breathe mode ramps the
// level 0..15..0 with one step every STEP_DIV cycles.
// Parameters:
//   STEP_DIV  - clock cycles per level step in breathe mode (>= 2)
//   DB_CYCLES - debounce length for the buttons (>= 2)
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   io        led_level_ctrl_if.slave (btn_up, btn_down, mode in;
//             duty_cycle, at_max, at_min out)
// Build option:
//   LED_LEVEL_GAMMA_EN - duty_cycle is the level mapped through the gamma
//                        table, one extra cycle of latency; at_max/at_min
//                        still follow the linear level.
// ----------------------------------------------------------------------------
module led_level_ctrl
    import led_level_pkg::*;
#(
    parameter int unsigned STEP_DIV  = 1_000_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    led_level_ctrl_if.slave  io
);

    localparam int unsigned      PRESC_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic press_up;
    logic press_down;
    logic mode_meta_q;
    logic mode_sync_q;

    state_e               state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 at_max_q, at_max_d;
    logic                 at_min_q, at_min_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (io.btn_up),
        .press   (press_up)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (io.btn_down),
        .press   (press_down)
    );

    // Mode switch is only synchronised; a bounce merely delays the ramp entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_meta_q <= 1'b0;
            mode_sync_q <= 1'b0;
        end else begin
            mode_meta_q <= io.mode;
            mode_sync_q <= mode_meta_q;
        end
    end

    // Level FSM: mode changes win over ramp ticks and button presses
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        presc_d = presc_q;

        case (state_q)
            MANUAL: begin
                if (mode_sync_q) begin
                    state_d = (level_q == LEVEL_MAX) ? RAMP_DOWN : RAMP_UP;
                    presc_d = '0;
                end else if (press_up && !press_down) begin
                    if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
                end else if (press_down && !press_up) begin
                    if (level_q != LEVEL_MIN) level_d = level_q - LEVEL_W'(1);
                end
            end

            RAMP_UP: begin
                if (!mode_sync_q) begin
                    state_d = MANUAL;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
                    if (level_d == LEVEL_MAX) state_d = RAMP_DOWN;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end

            RAMP_DOWN: begin
                if (!mode_sync_q) begin
                    state_d = MANUAL;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (level_q != LEVEL_MIN) level_d = level_q - LEVEL_W'(1);
                    if (level_d == LEVEL_MIN) state_d = RAMP_UP;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end

            default: begin
                state_d = MANUAL;
                presc_d = '0;
            end
        endcase

        // Flags track the next level so they line up with the registered level
        at_max_d = (level_d == LEVEL_MAX);
        at_min_d = (level_d == LEVEL_MIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MANUAL;
            level_q  <= '0;
            presc_q  <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            presc_q  <= presc_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign io.at_max = at_max_q;
    assign io.at_min = at_min_q;

`ifdef LED_LEVEL_GAMMA_EN
    logic [LEVEL_W-1:0] duty_q, duty_d;

    // Registered gamma map of the linear level
    always_comb begin
        duty_d = gamma_lookup(level_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign io.duty_cycle = duty_q;
`else
    assign io.duty_cycle = level_q;
`endif

endmodule

// File: tb/tb_led_level_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_level_ctrl
// Directed bench for led_level_ctrl with DB_CYCLES=4, STEP_DIV=3. Each clock
// the expected linear level is queued before the edge and compared just after.
// ----------------------------------------------------------------------------
module tb_led_level_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned SD = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    led_level_ctrl_if bus ();

    led_level_ctrl #(
        .STEP_DIV  (SD),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] lvl;
    logic [3:0] prev_lvl;
    logic [3:0] exp_q [$];

    function automatic logic [3:0] exp_duty(input logic [3:0] l);
`ifdef LED_LEVEL_GAMMA_EN
        case (l)
            4'd0, 4'd1:        return 4'd0;
            4'd2, 4'd3, 4'd4:  return 4'd1;
            4'd5, 4'd6:        return 4'd2;
            4'd7:              return 4'd3;
            4'd8:              return 4'd4;
            4'd9:              return 4'd5;
            4'd10:             return 4'd6;
            4'd11:             return 4'd7;
            4'd12:             return 4'd9;
            4'd13:             return 4'd11;
            4'd14:             return 4'd13;
            default:           return 4'd15;
        endcase
`else
        return l;
`endif
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] l);
        return (l == 4'd15) ? l : l + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] l);
        return (l == 4'd0) ? l : l - 4'd1;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Queue the expected level, advance one clock, then check the outputs
    task automatic tick(input string tag);
        logic [3:0] e;
        exp_q.push_back(lvl);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
`ifdef LED_LEVEL_GAMMA_EN
        cmp({tag, ".duty"}, 8'(bus.duty_cycle), 8'(exp_duty(prev_lvl)));
`else
        cmp({tag, ".duty"}, 8'(bus.duty_cycle), 8'(exp_duty(e)));
`endif
        cmp({tag, ".at_max"}, 8'(bus.at_max), 8'(e == 4'd15));
        cmp({tag, ".at_min"}, 8'(bus.at_min), 8'(e == 4'd0));
        prev_lvl = e;
    endtask

    // Clean press held 20 cycles; the level moves at the 8th clock after drive
    task automatic press(input logic up, input logic dn, input logic [3:0] new_lvl,
                         input string tag);
        bus.btn_up   = up;
        bus.btn_down = dn;
        for (int i = 1; i <= 20; i++) begin
            if (i == 8) lvl = new_lvl;
            tick(tag);
        end
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        repeat (12) tick(tag);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int j;
        reset        = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.mode     = 1'b0;
        lvl          = 4'd0;
        prev_lvl     = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        cmp("reset.duty",   8'(bus.duty_cycle), 8'd0);
        cmp("reset.at_max", 8'(bus.at_max),     8'd0);
        cmp("reset.at_min", 8'(bus.at_min),     8'd1);
        reset = 1'b0;

        repeat (50) tick("idle");

        // Exact latency of a clean press
        press(1'b1, 1'b0, 4'd1, "first_up");

        // Saturate at 15
        for (int i = 0; i < 17; i++) press(1'b1, 1'b0, sat_inc(lvl), "sat_up");

        // Down to 0 and one extra press at 0
        for (int i = 0; i < 16; i++) press(1'b0, 1'b1, sat_dec(lvl), "sat_down");

        // Glitches of 3 cycles are shorter than the debounce length
        repeat (3) begin
            bus.btn_up = 1'b1;
            repeat (3) tick("bounce");
            bus.btn_up = 1'b0;
            repeat (3) tick("bounce");
        end
        press(1'b1, 1'b0, 4'd1, "bounce_final");

        // Simultaneous presses cancel
        press(1'b1, 1'b1, 4'd1, "both");

        // Bring the level to 14
        for (int i = 0; i < 13; i++) press(1'b1, 1'b0, sat_inc(lvl), "to14");

        // Breathe from 14: up to 15, down to 0, back up to 9
        bus.mode = 1'b1;
        for (int t = 1; t <= 78; t++) begin
            if (t < 6) begin
                lvl = 4'd14;
            end else begin
                j   = (t - 6) / 3;
                lvl = (j <= 15) ? 4'(15 - j) : 4'(j - 15);
            end
            tick("ramp1");
        end

        // Back to manual: level freezes at 9
        bus.mode = 1'b0;
        repeat (20) tick("freeze");

        // Breathe from 9: up to 15, then down to 7
        bus.mode = 1'b1;
        for (int t = 1; t <= 46; t++) begin
            if (t < 6) begin
                lvl = 4'd9;
            end else begin
                j   = (t - 6) / 3;
                lvl = (j <= 5) ? 4'(10 + j) : 4'(20 - j);
            end
            tick("ramp2");
        end

        // Asynchronous reset mid-ramp
        reset = 1'b1;
        #1;
        cmp("async_rst.duty",   8'(bus.duty_cycle), 8'd0);
        cmp("async_rst.at_max", 8'(bus.at_max),     8'd0);
        cmp("async_rst.at_min", 8'(bus.at_min),     8'd1);
        bus.mode = 1'b0;
        lvl      = 4'd0;
        prev_lvl = 4'd0;
        repeat (2) tick("rst_hold");
        reset = 1'b0;
        repeat (10) tick("post_rst");

`ifdef LED_LEVEL_GAMMA_EN
        for (int i = 0; i < 12; i++) press(1'b1, 1'b0, sat_inc(lvl), "to12");
        cmp("gamma12.duty", 8'(bus.duty_cycle), 8'd9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
